// File: rtl/param_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy thresholds and sticky
// overflow/underflow flags. Status outputs are decoded from registered state only.
module param_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 32,
    parameter int AF_ESIK = DEPTH - 4,
    parameter int AE_ESIK = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       yaz_en_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       oku_en_i,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       temizle_i,
    input  logic                       hata_temizle_i,
    output logic                       fifo_bos,
    output logic                       fifo_dolu,
    output logic                       esik_dolu_o,
    output logic                       esik_bos_o,
    output logic [$clog2(DEPTH):0]     doluluk_o,
    output logic                       tasma_o,
    output logic                       alt_tasma_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_ESIK);
    localparam logic [CW-1:0] AE_C    = CW'(AE_ESIK);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             tasma_q, tasma_d;
    logic             alt_tasma_q, alt_tasma_d;
    logic             wr_ok_s, rd_ok_s;
    logic             full_s, empty_s;

    assign full_s      = (count_q == DEPTH_C);
    assign empty_s     = (count_q == {CW{1'b0}});
    assign fifo_dolu   = full_s;
    assign fifo_bos    = empty_s;
    assign esik_dolu_o = (count_q >= AF_C);
    assign esik_bos_o  = (count_q <= AE_C);
    assign doluluk_o   = count_q;
    assign tasma_o     = tasma_q;
    assign alt_tasma_o = alt_tasma_q;
    assign data_o      = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and sticky flags; flush beats read/write.
    always_comb begin
        wr_ok_s     = yaz_en_i && !full_s && !temizle_i;
        rd_ok_s     = oku_en_i && !empty_s && !temizle_i;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        tasma_d     = tasma_q;
        alt_tasma_d = alt_tasma_q;

        if (temizle_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A same-cycle error event takes precedence over the clear request.
        if (yaz_en_i && full_s && !temizle_i) begin
            tasma_d = 1'b1;
        end else if (hata_temizle_i) begin
            tasma_d = 1'b0;
        end else begin
            tasma_d = tasma_q;
        end
        if (oku_en_i && empty_s && !temizle_i) begin
            alt_tasma_d = 1'b1;
        end else if (hata_temizle_i) begin
            alt_tasma_d = 1'b0;
        end else begin
            alt_tasma_d = alt_tasma_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            tasma_q     <= 1'b0;
            alt_tasma_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tasma_q     <= tasma_d;
            alt_tasma_q <= alt_tasma_d;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: writes push expected words, a negedge monitor
// pops and compares data_o on every accepted read.
module tb_param_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       yaz_en_i, oku_en_i, temizle_i, hata_temizle_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       fifo_bos, fifo_dolu, esik_dolu_o, esik_bos_o;
    logic [5:0] doluluk_o;
    logic       tasma_o, alt_tasma_o;

    int         tests = 0;
    int         fails = 0;
    int         mcnt  = 0;
    logic [7:0] exp_q [$];

    param_fifo #(.WIDTH(8), .DEPTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .yaz_en_i(yaz_en_i), .data_i(data_i),
        .oku_en_i(oku_en_i), .data_o(data_o), .temizle_i(temizle_i),
        .hata_temizle_i(hata_temizle_i), .fifo_bos(fifo_bos), .fifo_dolu(fifo_dolu),
        .esik_dolu_o(esik_dolu_o), .esik_bos_o(esik_bos_o), .doluluk_o(doluluk_o),
        .tasma_o(tasma_o), .alt_tasma_o(alt_tasma_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every accepted pop must match the oldest scoreboard entry.
    always @(negedge clk_i) begin
        if (!rst_i && oku_en_i && !fifo_bos && !temizle_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 1, 0);
            end else begin
                chk("pop_data", int'(data_o), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; the bench's occupancy model decides acceptance.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic fl, input logic he);
        logic wacc, racc;
        yaz_en_i = w; data_i = d; oku_en_i = r; temizle_i = fl; hata_temizle_i = he;
        wacc = w && (mcnt != 32) && !fl;
        racc = r && (mcnt != 0) && !fl;
        if (fl) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            if (wacc) exp_q.push_back(d);
            mcnt = mcnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
        end
        @(posedge clk_i);
        #1;
        yaz_en_i = 1'b0; oku_en_i = 1'b0; temizle_i = 1'b0; hata_temizle_i = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, int'(doluluk_o), 0);
        chk({tag, "_bos"}, int'(fifo_bos), 1);
        chk({tag, "_dolu"}, int'(fifo_dolu), 0);
        chk({tag, "_esik_bos"}, int'(esik_bos_o), 1);
        chk({tag, "_esik_dolu"}, int'(esik_dolu_o), 0);
        chk({tag, "_tasma"}, int'(tasma_o), 0);
        chk({tag, "_alt_tasma"}, int'(alt_tasma_o), 0);
    endtask

    initial begin
        rst_i = 1'b1; yaz_en_i = 1'b0; oku_en_i = 1'b0; temizle_i = 1'b0;
        hata_temizle_i = 1'b0; data_i = 8'h00;
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_state("reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Fill 0x00..0x1F; almost-full asserts from count 28.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_esik_dolu", int'(esik_dolu_o), (i + 1 >= 28) ? 1 : 0);
        end
        chk("fill_count", int'(doluluk_o), 32);
        chk("fill_dolu", int'(fifo_dolu), 1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("overflow_tasma", int'(tasma_o), 1);
        chk("overflow_count", int'(doluluk_o), 32);
        chk("overflow_head", int'(data_o), 8'h00);

        // Drain; almost-empty asserts once count <= 4.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("drain_esik_bos", int'(esik_bos_o), (31 - i <= 4) ? 1 : 0);
        end
        chk("drain_bos", int'(fifo_bos), 1);
        chk("drain_alt_before", int'(alt_tasma_o), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("underflow_alt", int'(alt_tasma_o), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("hclr_tasma", int'(tasma_o), 0);
        chk("hclr_alt", int'(alt_tasma_o), 0);

        // Wrap: pointers start mid-array after 20+20, data crosses index 31->0.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("wrap_count", int'(doluluk_o), 20);
        chk("wrap_head", int'(data_o), 8'hA0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("wrap_bos", int'(fifo_bos), 1);

        // Simultaneous at full: read wins, write dropped, overflow flagged.
        for (int i = 0; i < 32; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("both_full_count", int'(doluluk_o), 31);
        chk("both_full_head", int'(data_o), 8'h41);
        chk("both_full_tasma", int'(tasma_o), 1);
        for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Simultaneous at empty: write wins, read rejected, underflow flagged.
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("both_empty_count", int'(doluluk_o), 1);
        chk("both_empty_head", int'(data_o), 8'h77);
        chk("both_empty_alt", int'(alt_tasma_o), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush at count 10 with a concurrent write; sticky flags survive.
        for (int i = 0; i < 10; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", int'(doluluk_o), 10);
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        chk("flush_count", int'(doluluk_o), 0);
        chk("flush_bos", int'(fifo_bos), 1);
        chk("flush_tasma_kept", int'(tasma_o), 1);
        chk("flush_alt_kept", int'(alt_tasma_o), 1);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        chk("post_flush_head", int'(data_o), 8'h33);
        chk("post_flush_count", int'(doluluk_o), 1);
        chk("hclr2_tasma", int'(tasma_o), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges at count 7 with a flag set.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_alt", int'(alt_tasma_o), 1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", int'(doluluk_o), 7);
        #2 rst_i = 1'b1;
        #1;
        chk_reset_state("midrst");
        exp_q.delete();
        mcnt = 0;
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("post_rst_count", int'(doluluk_o), 1);
        chk("post_rst_head", int'(data_o), 8'h99);

        // Overflow then clear; a same-cycle set beats the clear.
        for (int i = 0; i < 31; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        chk("ovf2_tasma", int'(tasma_o), 1);
        step(1'b1, 8'hFD, 1'b0, 1'b0, 1'b1);
        chk("set_beats_clear", int'(tasma_o), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("hclr3_tasma", int'(tasma_o), 0);
        for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("final_bos", int'(fifo_bos), 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 32, number of entries; power of two, >=2.
REQ-003 SHALL have parameter AF_ESIK, default DEPTH-4, almost-full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_ESIK, default 4, almost-empty threshold (0..DEPTH-1).
REQ-005 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous assert, active-high.
REQ-007 SHALL have port yaz_en_i  input  1  write request.
REQ-008 SHALL have port data_i  input  WIDTH  write data.
REQ-009 SHALL have port oku_en_i  input  1  read request (pop of current head).
REQ-010 SHALL have port data_o  output  WIDTH  head entry, first-word-fall-through.
REQ-011 SHALL have port temizle_i  input  1  synchronous flush.
REQ-012 SHALL have port hata_temizle_i  input  1  clears sticky error flags.
REQ-013 SHALL have port fifo_bos  output  1  empty (doluluk_o == 0).
REQ-014 SHALL have port fifo_dolu  output  1  full (doluluk_o == DEPTH).
REQ-015 SHALL have port esik_dolu_o  output  1  doluluk_o >= AF_ESIK.
REQ-016 SHALL have port esik_bos_o  output  1  doluluk_o <= AE_ESIK.
REQ-017 SHALL have port doluluk_o  output  clog2(DEPTH)+1  current occupancy.
REQ-018 SHALL have port tasma_o  output  1  sticky overflow.
REQ-019 SHALL have port alt_tasma_o  output  1  sticky underflow.

Function
REQ-020 Storage SHALL be DEPTH x WIDTH array; read/write pointers clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
REQ-021 Write accepted iff yaz_en_i && !fifo_dolu && !temizle_i: data_i stored at write pointer, pointer +1.
REQ-022 Read accepted iff oku_en_i && !fifo_bos && !temizle_i: read pointer +1; popped word is data_o during that cycle.
REQ-023 data_o SHALL equal array[read pointer] combinationally; zero added latency; value undefined when empty.
REQ-024 Write-to-read latency SHALL be 1 cycle: word written at edge N visible on data_o and fifo_bos low after edge N.
REQ-025 doluluk_o SHALL be a register: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-026 Full with both requests: read accepted, write rejected; result count DEPTH-1.
REQ-027 Empty with both requests: write accepted, read rejected; result count 1.
REQ-028 Neither full nor empty with both requests: both accepted, count unchanged.
REQ-029 All status outputs SHALL derive only from registered state (no combinational path from inputs).
REQ-030 temizle_i SHALL, at the next edge, zero both pointers and doluluk_o; has priority over same-cycle read/write; array content untouched.
REQ-031 yaz_en_i while fifo_dolu and !temizle_i SHALL set tasma_o; oku_en_i while fifo_bos and !temizle_i SHALL set alt_tasma_o.
REQ-032 hata_temizle_i SHALL clear both sticky flags at next edge; same-cycle set condition wins over clear.
REQ-033 temizle_i SHALL NOT clear sticky flags.

Reset
REQ-034 rst_i high SHALL immediately (asynchronously) zero pointers, doluluk_o, tasma_o, alt_tasma_o; fifo_bos=1, fifo_dolu=0, esik_bos_o=1, esik_dolu_o=0.
REQ-035 Array SHALL NOT be reset; deassertion synchronous to clk_i is the integrator's responsibility.
REQ-036 Reset mid-transfer SHALL discard all content; first post-reset write behaves as write to empty FIFO.

Verification
REQ-037 Fill: 32 writes 0x00..0x1F, no reads -> doluluk_o 32, fifo_dolu=1, esik_dolu_o=1 from count 28; 33rd write -> tasma_o=1, content unchanged.
REQ-038 Drain: 32 reads after fill -> data_o sequence 0x00..0x1F, fifo_bos=1, esik_bos_o=1 from count 4; extra read -> alt_tasma_o=1.
REQ-039 Wrap: 20 writes, 20 reads, 20 writes 0xA0..0xB3 -> reads return 0xA0..0xB3 in order across pointer wrap.
REQ-040 Simultaneous: at full, both requests -> count 31, head advances, data_i dropped; at empty, both -> count 1, data_o=data_i of that cycle.
REQ-041 Flush with yaz_en_i=1 at count 10 -> count 0, fifo_bos=1, written word discarded, sticky flags kept.
REQ-042 rst_i pulse mid-stream (between edges) at count 7 -> outputs per REQ-034 before next edge; hata_temizle_i after overflow clears tasma_o next cycle.
